// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol/disparity widths, the four DVI control
// tokens and a byte population count used by both encoder stages.
package tmds_pkg;

    localparam int CH_W   = 10;
    localparam int DISP_W = 5;

    localparam logic [CH_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [CH_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [CH_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [CH_W-1:0] CTRL_11 = 10'b1010101011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [CH_W-1:0] ctrl_token(input logic [1:0] c);
        logic [CH_W-1:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_encoder_ch.sv
// One TMDS channel: transition-minimising stage, then DC-balancing stage
// with its own running disparity.
module tmds_encoder_ch
    import tmds_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    input  logic [7:0]        s0_data,
    input  logic              s1_valid,
    input  logic              s1_de,
    input  logic [1:0]        s1_ctl,
    output logic [CH_W-1:0]   sym,
    output logic [DISP_W-1:0] cnt
);

    // XNOR chaining is XOR chaining with every link inverted.
    function automatic logic [8:0] min_trans(input logic [7:0] d);
        logic [3:0] n;
        logic       inv;
        logic [8:0] q;
        n    = popcount8(d);
        inv  = (n > 4'd4) || (n == 4'd4 && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = q[i-1] ^ d[i] ^ inv;
        end
        q[8] = !inv;
        return q;
    endfunction

    logic [8:0]               qm_q, qm_d;
    logic [CH_W-1:0]          sym_q, sym_d;
    logic signed [DISP_W-1:0] cnt_q, cnt_d;
    logic [3:0]               n1;
    logic signed [DISP_W-1:0] diff;
    logic signed [DISP_W-1:0] two_q8;

    always_comb begin
        qm_d = qm_q;
        if (s0_valid) begin
            qm_d = min_trans(s0_data);
        end
    end

    always_comb begin
        n1     = popcount8(qm_q[7:0]);
        diff   = $signed({n1, 1'b0}) - 5'sd8;
        two_q8 = qm_q[8] ? 5'sd2 : 5'sd0;
        sym_d  = sym_q;
        cnt_d  = cnt_q;
        if (s1_valid) begin
            if (!s1_de) begin
                sym_d = ctrl_token(s1_ctl);
                cnt_d = '0;
            end else if (cnt_q == 5'sd0 || diff == 5'sd0) begin
                sym_d = {~qm_q[8], qm_q[8],
                         qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
            end else if ((cnt_q > 5'sd0 && diff > 5'sd0) ||
                         (cnt_q < 5'sd0 && diff < 5'sd0)) begin
                sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d = cnt_q + two_q8 - diff;
            end else begin
                sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d = cnt_q + diff - (5'sd2 - two_q8);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qm_q  <= '0;
            sym_q <= '0;
            cnt_q <= '0;
        end else begin
            qm_q  <= qm_d;
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym = sym_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/tmds_encoder_3ch.sv
// Three-channel DVI TMDS encoder (ch0 blue + syncs, ch1 green, ch2 red),
// fixed two-cycle latency, no backpressure.
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter logic [1:0] CTL_CH1 = 2'b00,
    parameter logic [1:0] CTL_CH2 = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] pixel,
    output logic        valid_out,
    output logic [29:0] data_out,
    output logic [14:0] disparity
);

    logic       v1_q, v1_d;
    logic       v2_q, v2_d;
    logic       de1_q, de1_d;
    logic [1:0] sync1_q, sync1_d;

    logic [2:0][1:0]        ctl1;
    logic [2:0][CH_W-1:0]   sym;
    logic [2:0][DISP_W-1:0] cnt;

    always_comb begin
        v1_d    = valid_in;
        v2_d    = v1_q;
        de1_d   = de1_q;
        sync1_d = sync1_q;
        if (valid_in) begin
            de1_d   = de;
            sync1_d = {vsync, hsync};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            de1_q   <= 1'b0;
            sync1_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            de1_q   <= de1_d;
            sync1_q <= sync1_d;
        end
    end

    assign ctl1 = {CTL_CH2, CTL_CH1, sync1_q};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        tmds_encoder_ch u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .s0_valid (valid_in),
            .s0_data  (pixel[8*g +: 8]),
            .s1_valid (v1_q),
            .s1_de    (de1_q),
            .s1_ctl   (ctl1[g]),
            .sym      (sym[g]),
            .cnt      (cnt[g])
        );
    end

    assign valid_out = v2_q;
    assign data_out  = sym;
    assign disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Randomised self-checking bench for tmds_encoder_3ch against a
// behavioural DVI encode/decode model.
module tb_tmds_encoder_3ch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] pixel;
    logic        valid_out;
    logic [29:0] data_out;
    logic [14:0] disparity;

    tmds_encoder_3ch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .pixel     (pixel),
        .valid_out (valid_out),
        .data_out  (data_out),
        .disparity (disparity)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] ctok [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};

    // model state: expected outputs plus the beat captured at the last edge
    bit          exp_v;
    logic [29:0] exp_d;
    int          ecnt [3];
    bit          exp_new_data;
    int          exp_bytes [3];
    bit          p_v, p_de, p_hs, p_vs;
    logic [23:0] p_px;

    function automatic int ones(input int x);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += (x >> i) & 1;
        return n;
    endfunction

    task automatic model_beat(input int d, inout int cnt,
                              output logic [9:0] sym);
        int q8, qm, prev, b, n1, n0;
        q8 = (ones(d) > 4 || (ones(d) == 4 && d % 2 == 0)) ? 0 : 1;
        prev = d & 1;
        qm = prev;
        for (int i = 1; i < 8; i++) begin
            b = (d >> i) & 1;
            prev = q8 ? (prev ^ b) : 1 - (prev ^ b);
            qm |= prev << i;
        end
        n1 = ones(qm);
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            sym = q8 ? 10'(256 + qm) : 10'(512 + (qm ^ 255));
            cnt += q8 ? n1 - n0 : n0 - n1;
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            sym = 10'(512 + q8 * 256 + (qm ^ 255));
            cnt += 2 * q8 + n0 - n1;
        end else begin
            sym = 10'(q8 * 256 + qm);
            cnt += n1 - n0 - 2 * (1 - q8);
        end
    endtask

    function automatic int tmds_decode(input logic [9:0] s);
        int q, d, b;
        q = int'(s[7:0]);
        if (s[9]) q ^= 255;
        d = q & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((q >> i) ^ (q >> (i - 1))) & 1;
            if (!s[8]) b ^= 1;
            d |= b << i;
        end
        return d;
    endfunction

    function automatic logic [14:0] exp_disp();
        return {5'(ecnt[2]), 5'(ecnt[1]), 5'(ecnt[0])};
    endfunction

    task automatic tick(input bit rst, input bit v, input bit d_i,
                        input bit hs, input bit vs,
                        input logic [23:0] px);
        logic [9:0] s;
        rst_n    = !rst;
        valid_in = v;
        de       = d_i;
        hsync    = hs;
        vsync    = vs;
        pixel    = px;
        @(posedge clk);
        #1;
        exp_new_data = 1'b0;
        if (rst) begin
            exp_v = 1'b0;
            exp_d = '0;
            ecnt  = '{0, 0, 0};
            p_v   = 1'b0;
        end else begin
            exp_v = p_v;
            if (p_v && p_de) begin
                exp_new_data = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    exp_bytes[c] = int'(p_px[8*c +: 8]);
                    model_beat(exp_bytes[c], ecnt[c], s);
                    exp_d[10*c +: 10] = s;
                end
            end else if (p_v) begin
                exp_d = {ctok[0], ctok[0], ctok[{p_vs, p_hs}]};
                ecnt  = '{0, 0, 0};
            end
            p_v  = v;
            p_de = d_i;
            p_hs = hs;
            p_vs = vs;
            p_px = px;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 24'($urandom));
            vectors++;
            if ({valid_out, data_out, disparity} !== 46'd0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h want 0",
                         {valid_out, data_out, disparity});
            end
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom));
        vectors++;
        if (valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lat1: valid_out got %b want 0", valid_out);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom));
        vectors++;
        if ({valid_out, data_out, disparity} !==
            {1'b1, exp_d, exp_disp()}) begin
            miscompares++;
            $display("FAIL reset_first: got %h want %h",
                     {valid_out, data_out, disparity},
                     {1'b1, exp_d, exp_disp()});
        end
    endtask

    task automatic test_blanking();
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'($urandom));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 24'($urandom));
        vectors++;
        if ({valid_out, data_out, disparity} !==
            {1'b1, 10'b1101010100, 10'b1101010100,
             10'b0010101011, 15'd0}) begin
            miscompares++;
            $display("FAIL blanking: got %h want %h",
                     {valid_out, data_out, disparity},
                     {1'b1, 10'b1101010100, 10'b1101010100,
                      10'b0010101011, 15'd0});
        end
    endtask

    task automatic test_blue();
        logic [9:0]        ech0 [3] = '{10'h100, 10'h3FF, 10'h100};
        logic signed [4:0] ec0 [3]  = '{-5'sd8, 5'sd2, -5'sd6};
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, i < 4, i >= 1, 1'($urandom), 1'($urandom),
                 {16'($urandom), 8'h00});
            vectors++;
            if ({valid_out, data_out, disparity} !==
                {exp_v, exp_d, exp_disp()}) begin
                miscompares++;
                $display("FAIL blue_model: got %h want %h",
                         {valid_out, data_out, disparity},
                         {exp_v, exp_d, exp_disp()});
            end
            if (i >= 2 && i <= 4) begin
                vectors++;
                if ({data_out[9:0], disparity[4:0]} !==
                    {ech0[i-2], ec0[i-2]}) begin
                    miscompares++;
                    $display("FAIL blue_seq%0d: got %h/%0d want %h/%0d",
                             i - 2, data_out[9:0], $signed(disparity[4:0]),
                             ech0[i-2], ec0[i-2]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        bit                vp [9]   = '{1, 1, 0, 1, 0, 1, 0, 0, 0};
        logic [9:0]        ech0 [3] = '{10'h100, 10'h3FF, 10'h100};
        logic signed [4:0] ec0 [3]  = '{-5'sd8, 5'sd2, -5'sd6};
        int k;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, vp[i], i >= 1, 1'b0, 1'b0, {16'($urandom), 8'h00});
            vectors++;
            if ({valid_out, data_out, disparity} !==
                {exp_v, exp_d, exp_disp()}) begin
                miscompares++;
                $display("FAIL gaps_model: got %h want %h",
                         {valid_out, data_out, disparity},
                         {exp_v, exp_d, exp_disp()});
            end
            if (i >= 2 && vp[i-1] && k < 3) begin
                vectors++;
                if ({valid_out, data_out[9:0], disparity[4:0]} !==
                    {1'b1, ech0[k], ec0[k]}) begin
                    miscompares++;
                    $display("FAIL gaps_beat%0d: got %b/%h/%0d want 1/%h/%0d",
                             k, valid_out, data_out[9:0],
                             $signed(disparity[4:0]), ech0[k], ec0[k]);
                end
                k++;
            end else if (i >= 3 && !vp[i-1] && k > 0) begin
                vectors++;
                if ({valid_out, data_out[9:0], disparity[4:0]} !==
                    {1'b0, ech0[k-1], ec0[k-1]}) begin
                    miscompares++;
                    $display("FAIL gaps_hold: got %b/%h/%0d want 0/%h/%0d",
                             valid_out, data_out[9:0],
                             $signed(disparity[4:0]), ech0[k-1], ec0[k-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        int          left;
        bit          cur_de;
        bit          v;
        logic [23:0] px;
        int          sel;
        bit          ok;
        left   = 0;
        cur_de = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 4) != 0);
            if (v) begin
                if (left == 0) begin
                    cur_de = !cur_de;
                    left = cur_de ? $urandom_range(1, 40)
                                  : $urandom_range(1, 6);
                end
                left--;
            end
            px = 24'($urandom);
            for (int c = 0; c < 3; c++) begin
                sel = $urandom_range(0, 7);
                if (sel == 0) px[8*c +: 8] = 8'h00;
                if (sel == 1) px[8*c +: 8] = 8'hFF;
            end
            tick(1'b0, v, cur_de, 1'($urandom), 1'($urandom), px);
            vectors++;
            if ({valid_out, data_out, disparity} !==
                {exp_v, exp_d, exp_disp()}) begin
                miscompares++;
                $display("FAIL rand_model: beat %0d got %h want %h", i,
                         {valid_out, data_out, disparity},
                         {exp_v, exp_d, exp_disp()});
            end
            ok = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if ($signed(disparity[5*c +: 5]) > 5'sd10 ||
                    $signed(disparity[5*c +: 5]) < -5'sd10) ok = 1'b0;
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL rand_bound: beat %0d disparity %h want |cnt|<=10",
                         i, disparity);
            end
            if (exp_new_data) begin
                for (int c = 0; c < 3; c++) begin
                    vectors++;
                    if (tmds_decode(data_out[10*c +: 10]) != exp_bytes[c]) begin
                        miscompares++;
                        $display("FAIL rand_decode: ch%0d got %h want %h", c,
                                 tmds_decode(data_out[10*c +: 10]),
                                 exp_bytes[c]);
                    end
                end
            end
        end
    endtask

    task automatic test_midreset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom));
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom));
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom));
        vectors++;
        if ({valid_out, data_out, disparity} !== 46'd0) begin
            miscompares++;
            $display("FAIL midreset_flush: got %h want 0",
                     {valid_out, data_out, disparity});
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {16'($urandom), 8'h00});
        vectors++;
        if ({valid_out, data_out, disparity} !== 46'd0) begin
            miscompares++;
            $display("FAIL midreset_drain: got %h want 0",
                     {valid_out, data_out, disparity});
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom));
        vectors++;
        if ({valid_out, data_out[9:0], disparity[4:0]} !==
            {1'b1, 10'h100, -5'sd8}) begin
            miscompares++;
            $display("FAIL midreset_restart: got %b/%h/%0d want 1/100/-8",
                     valid_out, data_out[9:0], $signed(disparity[4:0]));
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, i < 4, 1'b1, 1'b0, 1'b0, 24'($urandom));
            vectors++;
            if ({valid_out, data_out, disparity} !==
                {exp_v, exp_d, exp_disp()}) begin
                miscompares++;
                $display("FAIL midreset_model: got %h want %h",
                         {valid_out, data_out, disparity},
                         {exp_v, exp_d, exp_disp()});
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        de       = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        pixel    = '0;
        exp_v    = 1'b0;
        exp_d    = '0;
        ecnt     = '{0, 0, 0};
        p_v      = 1'b0;
        test_reset();
        test_blanking();
        test_blue();
        test_gaps();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
